coin_acceptor: RTL and testbench

- Front-end stage directly upstream of the vending FSM.
- Takes two raw, bouncy, asynchronous coin-slot sensor lines (5 and 10 units), synchronizes and debounces them, and rejects illegal or inhibited insertions.
- Emits exactly one single-cycle coin code per physical coin on the 2-bit coin bus: 00 idle, 01 = 5, 10 = 10, 11 never driven.
- Also reports rejects and keeps a saturating reject counter for diagnostics.

---
 rtl/coin_acceptor_if.sv | 33 +++
 rtl/coin_acceptor.sv | 141 ++++++++++++++
 tb/tb_coin_acceptor.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_acceptor_if.sv
// Coin front-end bus: raw slot sensors and accept enable toward the acceptor,
// debounced coin code, reject pulse and diagnostics back to the vending side.
interface coin_acceptor_if;
  logic       coin5_raw;
  logic       coin10_raw;
  logic       accept_en;
  logic [1:0] coin;
  logic       reject;
  logic       busy;
  logic [7:0] reject_cnt;

  // Environment / vending side: drives sensors and enable, consumes results
  modport master (
    output coin5_raw,
    output coin10_raw,
    output accept_en,
    input  coin,
    input  reject,
    input  busy,
    input  reject_cnt
  );

  // Acceptor side
  modport slave (
    input  coin5_raw,
    input  coin10_raw,
    input  accept_en,
    output coin,
    output reject,
    output busy,
    output reject_cnt
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front-end: two-flop synchronizers on both slot sensors, a
// debounce/validation FSM, single-cycle coin/reject pulses and a saturating
// reject counter for diagnostics.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  coin_acceptor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2
  } state_t;

  // Counter value at which the next stable sample completes a full run
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [1:0]       sync5_q;
  logic [1:0]       sync10_q;
  logic [1:0]       samp_s;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       cand_q;
  logic [1:0]       coin_q;
  logic             reject_q;
  logic             busy_q;
  logic [7:0]       rej_cnt_q;

  // Saturating increment so the diagnostic counter never wraps
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Synchronized sample bus: bit 1 = 10-unit line, bit 0 = 5-unit line,
  // which makes the sample value identical to the coin code it would produce
  assign samp_s = {sync10_q[1], sync5_q[1]};

  // Two-flop synchronizers for the asynchronous sensor lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync5_q  <= 2'b00;
      sync10_q <= 2'b00;
    end else begin
      sync5_q  <= {sync5_q[0], bus.coin5_raw};
      sync10_q <= {sync10_q[0], bus.coin10_raw};
    end
  end

  // Debounce/validation FSM with registered pulse outputs and reject counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      cand_q    <= 2'b00;
      coin_q    <= 2'b00;
      reject_q  <= 1'b0;
      busy_q    <= 1'b0;
      rej_cnt_q <= 8'd0;
    end else begin
      // Pulses last one cycle unless re-asserted below
      coin_q   <= 2'b00;
      reject_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (samp_s == 2'b01 || samp_s == 2'b10) begin
            cand_q  <= samp_s;
            cnt_q   <= CNT_ONE;
            state_q <= ST_DEBOUNCE;
            busy_q  <= 1'b1;
          end else if (samp_s == 2'b11) begin
            // Both slots at once cannot be a legal single coin
            reject_q  <= 1'b1;
            rej_cnt_q <= sat_inc(rej_cnt_q);
            cnt_q     <= CNT_ZERO;
            state_q   <= ST_RELEASE;
            busy_q    <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_DEBOUNCE: begin
          if (samp_s == 2'b00) begin
            // Too short to be a coin: drop silently
            cnt_q   <= CNT_ZERO;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (samp_s != cand_q) begin
            reject_q  <= 1'b1;
            rej_cnt_q <= sat_inc(rej_cnt_q);
            cnt_q     <= CNT_ZERO;
            state_q   <= ST_RELEASE;
          end else if (cnt_q == CNT_LAST) begin
            // accept_en only matters on this edge
            if (bus.accept_en) begin
              coin_q <= cand_q;
            end else begin
              reject_q  <= 1'b1;
              rej_cnt_q <= sat_inc(rej_cnt_q);
            end
            cnt_q   <= CNT_ZERO;
            state_q <= ST_RELEASE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (samp_s != 2'b00) begin
            cnt_q <= CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= CNT_ZERO;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_q   <= CNT_ZERO;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.coin       = coin_q;
  assign bus.reject     = reject_q;
  assign bus.busy       = busy_q;
  assign bus.reject_cnt = rej_cnt_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus random
// sensor traffic, each cycle compared against a history-based reference model.
module tb_coin_acceptor;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  coin_acceptor_if bus ();

  coin_acceptor #(.DEBOUNCE_CYCLES(N), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: raw levels per edge, synchronized samples per edge
  logic [1:0]  rhist [0:16383];
  logic [1:0]  shist [0:16383];
  int          t = 0;        // index of the next rising edge
  int          first_t = 0;  // first edge after the latest reset
  int          m_mode = 0;   // 0 waiting, 1 qualifying a coin, 2 waiting for slots to clear
  int          start_t = 0;
  int          drain_t = 0;
  logic [1:0]  cand = 2'b00;
  int          m_cnt = 0;
  logic [11:0] m_exp = 12'h000;
  wire  [11:0] obs = {bus.coin, bus.reject, bus.busy, bus.reject_cnt};

  task automatic model_clear();
    m_mode = 0;
    m_cnt  = 0;
    cand   = 2'b00;
    m_exp  = 12'h000;
  endtask

  // Decide what the acceptor must show after edge t
  task automatic model_edge(input logic en);
    logic [1:0] s;
    logic [1:0] e_coin;
    logic       e_rej;
    bit         quiet;
    s = (t - 2 >= first_t) ? rhist[t-2] : 2'b00;
    shist[t] = s;
    e_coin = 2'b00;
    e_rej  = 1'b0;
    case (m_mode)
      0: begin
        if (s == 2'b01 || s == 2'b10) begin
          m_mode = 1; cand = s; start_t = t;
        end else if (s == 2'b11) begin
          e_rej = 1'b1; m_mode = 2; drain_t = t;
        end
      end
      1: begin
        if (s == 2'b00) begin
          m_mode = 0;
        end else if (s != cand) begin
          e_rej = 1'b1; m_mode = 2; drain_t = t;
        end else if (t - start_t + 1 == N) begin
          if (en) e_coin = cand;
          else    e_rej = 1'b1;
          m_mode = 2; drain_t = t;
        end
      end
      default: begin
        // Leave once the last N samples since the event were all quiet
        quiet = (t - drain_t >= N);
        for (int i = 0; i < N; i++)
          if (t - i >= 0 && shist[t-i] != 2'b00) quiet = 0;
        if (quiet) m_mode = 0;
      end
    endcase
    if (e_rej && m_cnt < 255) m_cnt++;
    m_exp = {e_coin, e_rej, (m_mode != 0), 8'(m_cnt)};
  endtask

  // One clock: drive at negedge, model at posedge, return at next negedge
  task automatic step(input logic c5, input logic c10, input logic en);
    bus.coin5_raw  = c5;
    bus.coin10_raw = c10;
    bus.accept_en  = en;
    rhist[t] = {c10, c5};
    @(posedge clk);
    model_edge(en);
    t++;
    @(negedge clk);
  endtask

  // Hold reset over two edges and release it mid-cycle
  task automatic finish_reset();
    model_clear();
    repeat (2) begin
      rhist[t] = {bus.coin10_raw, bus.coin5_raw};
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    rst_n   = 1'b1;
    first_t = t;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.coin5_raw = 1'b0; bus.coin10_raw = 1'b0; bus.accept_en = 1'b1;
    finish_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.coin5_raw = 1'b0; bus.coin10_raw = 1'b0; bus.accept_en = 1'b1;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL reset_state got=%h exp=000", obs);
    end
    finish_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== m_exp) begin
        errors++; $display("FAIL reset_idle t=%0d got=%h exp=%h", t, obs, m_exp);
      end
    end
  endtask

  task automatic test_clean_coin5();
    int k, pulses, pulse_t;
    do_reset();
    k = t; pulses = 0; pulse_t = -1;
    for (int i = 0; i < 22; i++) begin
      step(i < 12, 1'b0, 1'b1);
      checks++;
      if (obs !== m_exp) begin
        errors++; $display("FAIL clean5 t=%0d got=%h exp=%h", t - 1, obs, m_exp);
      end
      if (bus.coin != 2'b00) begin pulses++; pulse_t = t - 1; end
    end
    checks++;
    if (pulses != 1 || pulse_t != k + 5) begin
      errors++; $display("FAIL clean5_latency got pulses=%0d at edge %0d exp 1 at edge %0d", pulses, pulse_t, k + 5);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.reject_cnt !== 8'd0) begin
      errors++; $display("FAIL clean5_end got busy=%b cnt=%0d exp busy=0 cnt=0", bus.busy, bus.reject_cnt);
    end
  endtask

  task automatic test_bounce10();
    int n5, n10;
    logic pat [0:23];
    do_reset();
    n5 = 0; n10 = 0;
    for (int i = 0; i < 24; i++) pat[i] = (i < 4) ? (i % 2 == 0) : (i < 14);
    for (int i = 0; i < 24; i++) begin
      step(1'b0, pat[i], 1'b1);
      checks++;
      if (obs !== m_exp) begin
        errors++; $display("FAIL bounce10 t=%0d got=%h exp=%h", t - 1, obs, m_exp);
      end
      if (bus.coin == 2'b10) n10++;
      if (bus.coin == 2'b01) n5++;
    end
    checks++;
    if (n10 != 1 || n5 != 0 || bus.reject_cnt !== 8'd0) begin
      errors++; $display("FAIL bounce10_count got n10=%0d n5=%0d cnt=%0d exp 1 0 0", n10, n5, bus.reject_cnt);
    end
  endtask

  task automatic test_short_press();
    int events;
    do_reset();
    events = 0;
    for (int i = 0; i < 12; i++) begin
      step(i < 2, 1'b0, 1'b1);
      checks++;
      if (obs !== m_exp) begin
        errors++; $display("FAIL short t=%0d got=%h exp=%h", t - 1, obs, m_exp);
      end
      if (bus.coin != 2'b00 || bus.reject) events++;
    end
    checks++;
    if (events != 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL short_end got events=%0d busy=%b exp 0 0", events, bus.busy);
    end
  endtask

  task automatic test_both_lines();
    int rejs, early, late;
    do_reset();
    rejs = 0; early = 0; late = 0;
    // 8 both, 2 low, 6 coin5 (too early), 6 low, 8 coin5, 8 low
    for (int i = 0; i < 38; i++) begin
      step((i >= 10 && i < 16) || (i >= 22 && i < 30) || (i < 8), i < 8, 1'b1);
      checks++;
      if (obs !== m_exp) begin
        errors++; $display("FAIL both t=%0d got=%h exp=%h", t - 1, obs, m_exp);
      end
      if (bus.reject) rejs++;
      if (bus.coin != 2'b00 && i < 22) early++;
      if (bus.coin == 2'b01 && i >= 22) late++;
    end
    checks++;
    if (rejs != 1 || early != 0 || late != 1 || bus.reject_cnt !== 8'd1) begin
      errors++; $display("FAIL both_count got rej=%0d early=%0d late=%0d cnt=%0d exp 1 0 1 1", rejs, early, late, bus.reject_cnt);
    end
  endtask

  task automatic test_inhibit_saturate();
    int rejs, coins;
    do_reset();
    rejs = 0; coins = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, i < 8, 1'b0);
      checks++;
      if (obs !== m_exp) begin
        errors++; $display("FAIL inhibit t=%0d got=%h exp=%h", t - 1, obs, m_exp);
      end
      if (bus.reject) rejs++;
      if (bus.coin != 2'b00) coins++;
    end
    checks++;
    if (rejs != 1 || coins != 0 || bus.reject_cnt !== 8'd1) begin
      errors++; $display("FAIL inhibit_count got rej=%0d coins=%0d cnt=%0d exp 1 0 1", rejs, coins, bus.reject_cnt);
    end
    for (int r = 0; r < 256; r++) begin
      for (int i = 0; i < 7; i++) begin
        step(i == 0, i == 0, 1'($urandom_range(0, 1)));
        checks++;
        if (obs !== m_exp) begin
          errors++; $display("FAIL saturate t=%0d got=%h exp=%h", t - 1, obs, m_exp);
        end
        if (bus.reject) rejs++;
      end
    end
    checks++;
    if (rejs != 257 || bus.reject_cnt !== 8'd255) begin
      errors++; $display("FAIL saturate_end got rej=%0d cnt=%0d exp 257 255", rejs, bus.reject_cnt);
    end
  endtask

  task automatic test_reset_then_vend();
    logic [1:0] seq [$];
    int credit, stray, vend_at;
    logic [1:0] which [0:2];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1);
      checks++;
      if (obs !== m_exp) begin
        errors++; $display("FAIL midreset_pre t=%0d got=%h exp=%h", t - 1, obs, m_exp);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL midreset_async got=%h exp=000", obs);
    end
    bus.coin5_raw = 1'b0;
    finish_reset();
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== m_exp) begin
        errors++; $display("FAIL midreset_post t=%0d got=%h exp=%h", t - 1, obs, m_exp);
      end
      if (bus.coin != 2'b00 || bus.reject) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL midreset_stray got=%0d exp=0", stray);
    end
    which[0] = 2'b01; which[1] = 2'b01; which[2] = 2'b10;
    credit = 0; vend_at = -1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 16; i++) begin
        step(i < 8 && which[c] == 2'b01, i < 8 && which[c] == 2'b10, 1'b1);
        checks++;
        if (obs !== m_exp) begin
          errors++; $display("FAIL vend t=%0d got=%h exp=%h", t - 1, obs, m_exp);
        end
        if (bus.coin != 2'b00) begin
          seq.push_back(bus.coin);
          credit += (bus.coin == 2'b01) ? 5 : 10;
          if (credit >= 20 && vend_at < 0) vend_at = seq.size();
        end
      end
    end
    checks++;
    if (seq.size() != 3 || seq[0] !== 2'b01 || seq[1] !== 2'b01 || seq[2] !== 2'b10) begin
      errors++; $display("FAIL vend_seq got %0d coins exp 01,01,10", seq.size());
    end
    checks++;
    if (credit != 20 || vend_at != 3) begin
      errors++; $display("FAIL vend_total got credit=%0d vend_at=%0d exp 20 3", credit, vend_at);
    end
  endtask

  task automatic test_random();
    int bad;
    logic c5, c10;
    int len;
    do_reset();
    bad = 0;
    for (int s = 0; s < 120; s++) begin
      c5  = 1'($urandom_range(0, 1));
      c10 = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        step(c5, c10, $urandom_range(0, 3) != 0);
        checks++;
        if (obs !== m_exp) begin
          errors++; $display("FAIL random t=%0d got=%h exp=%h", t - 1, obs, m_exp);
        end
        if (bus.coin == 2'b11 || (bus.coin != 2'b00 && bus.reject)) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL random_exclusive got=%0d exp=0", bad);
    end
  endtask

  initial begin
    bus.coin5_raw  = 1'b0;
    bus.coin10_raw = 1'b0;
    bus.accept_en  = 1'b1;
    @(negedge clk);
    test_reset();
    test_clean_coin5();
    test_bounce10();
    test_short_press();
    test_both_lines();
    test_inhibit_saturate();
    test_reset_then_vend();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
